// File: rtl/argon_regbank.sv
// Multi-read-port register file with write-to-read bypass, busy scoreboard and
// a post-reset clear sweep (r0 hard-wired to zero).
module argon_regbank #(
    parameter int REGISTERS  = 16,
    parameter int INDEXWIDTH = 4,
    parameter int DATAWIDTH  = 16,
    parameter int READPORTS  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_writeEn,
    input  logic [INDEXWIDTH-1:0]           i_selectW,
    input  logic [DATAWIDTH-1:0]            i_wdata,
    input  logic                            i_reserveEn,
    input  logic [INDEXWIDTH-1:0]           i_selectRes,
    input  logic [READPORTS*INDEXWIDTH-1:0] i_selectR,
    output logic [READPORTS*DATAWIDTH-1:0]  o_rdata,
    output logic [READPORTS-1:0]            o_busy,
    output logic                            o_ready
);

    localparam int DEPTH = 1 << INDEXWIDTH;
    localparam logic [INDEXWIDTH-1:0] LAST_IDX = INDEXWIDTH'(REGISTERS - 1);

    typedef enum logic [1:0] {
        CLEAR,
        SWEEP,
        READY
    } state_t;

    state_t                  state, state_next;
    logic [INDEXWIDTH-1:0]   sweep_idx, sweep_idx_next;
    logic                    sweeping;
    logic                    ready;
    logic                    write_ok;
    logic                    reserve_ok;
    logic [DATAWIDTH-1:0]    regfile [DEPTH];
    logic [DEPTH-1:0]        busybit;

    function automatic logic in_range(input logic [INDEXWIDTH-1:0] idx);
        return (idx != '0) && (32'(idx) < REGISTERS);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= CLEAR;
            sweep_idx <= INDEXWIDTH'(1);
        end else begin
            state     <= state_next;
            sweep_idx <= sweep_idx_next;
        end
    end

    // CLEAR already sweeps index 1 so ready rises REGISTERS-1 edges after release.
    always_comb begin
        state_next     = state;
        sweep_idx_next = sweep_idx;
        sweeping       = 1'b0;
        case (state)
            CLEAR, SWEEP: begin
                sweeping       = 1'b1;
                sweep_idx_next = sweep_idx + INDEXWIDTH'(1);
                state_next     = (sweep_idx == LAST_IDX) ? READY : SWEEP;
            end
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    assign ready      = (state == READY);
    assign o_ready    = ready;
    assign write_ok   = ready && i_writeEn && in_range(i_selectW);
    assign reserve_ok = ready && i_reserveEn && in_range(i_selectRes);

    // Storage has a single write port and no reset so it maps onto RAM.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (sweeping) begin
                regfile[sweep_idx] <= '0;
            end else if (write_ok) begin
                regfile[i_selectW] <= i_wdata;
            end
        end
    end

    // Reserve is applied after write so it wins on a shared index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busybit <= '0;
        end else begin
            if (write_ok) begin
                busybit[i_selectW] <= 1'b0;
            end
            if (reserve_ok) begin
                busybit[i_selectRes] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        o_busy  = '0;
        for (int unsigned p = 0; p < READPORTS; p++) begin
            if (ready && in_range(i_selectR[p*INDEXWIDTH +: INDEXWIDTH])) begin
                if (i_writeEn && (i_selectW == i_selectR[p*INDEXWIDTH +: INDEXWIDTH])) begin
                    o_rdata[p*DATAWIDTH +: DATAWIDTH] = i_wdata;
                end else begin
                    o_rdata[p*DATAWIDTH +: DATAWIDTH] = regfile[i_selectR[p*INDEXWIDTH +: INDEXWIDTH]];
                    o_busy[p] = busybit[i_selectR[p*INDEXWIDTH +: INDEXWIDTH]];
                end
            end
        end
    end

endmodule

// File: tb/tb_argon_regbank.sv
// Scoreboard bench for argon_regbank: a default 16x2 bank and a 12-register,
// four-port bank, with directed cases plus a model-driven random phase.
module tb_argon_regbank;

    localparam int A_DATA  = 0;
    localparam int A_BUSY  = 1;
    localparam int A_READY = 2;
    localparam int B_DATA  = 3;
    localparam int B_BUSY  = 4;
    localparam int B_READY = 5;

    typedef struct {
        string       tag;
        int          which;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        a_reset, a_we, a_re;
    logic [3:0]  a_selw, a_selres;
    logic [15:0] a_wdata;
    logic [7:0]  a_selr;
    logic [31:0] a_rdata;
    logic [1:0]  a_busy;
    logic        a_ready;

    logic        b_reset, b_we, b_re;
    logic [3:0]  b_selw, b_selres;
    logic [15:0] b_wdata;
    logic [15:0] b_selr;
    logic [63:0] b_rdata;
    logic [3:0]  b_busy;
    logic        b_ready;

    always #5 clk = ~clk;

    argon_regbank dut_a (
        .i_clk       (clk),
        .i_reset     (a_reset),
        .i_writeEn   (a_we),
        .i_selectW   (a_selw),
        .i_wdata     (a_wdata),
        .i_reserveEn (a_re),
        .i_selectRes (a_selres),
        .i_selectR   (a_selr),
        .o_rdata     (a_rdata),
        .o_busy      (a_busy),
        .o_ready     (a_ready)
    );

    argon_regbank #(
        .REGISTERS  (12),
        .INDEXWIDTH (4),
        .DATAWIDTH  (16),
        .READPORTS  (4)
    ) dut_b (
        .i_clk       (clk),
        .i_reset     (b_reset),
        .i_writeEn   (b_we),
        .i_selectW   (b_selw),
        .i_wdata     (b_wdata),
        .i_reserveEn (b_re),
        .i_selectRes (b_selres),
        .i_selectR   (b_selr),
        .o_rdata     (b_rdata),
        .o_busy      (b_busy),
        .o_ready     (b_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int which, input int port, input logic [63:0] exp);
        exp_t e;
        e.tag = tag; e.which = which; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t        e;
        logic [63:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.which)
                A_DATA:  act = 64'(a_rdata[e.port*16 +: 16]);
                A_BUSY:  act = 64'(a_busy[e.port]);
                A_READY: act = 64'(a_ready);
                B_DATA:  act = 64'(b_rdata[e.port*16 +: 16]);
                B_BUSY:  act = 64'(b_busy[e.port]);
                default: act = 64'(b_ready);
            endcase
            check(e.tag, act, e.exp);
        end
    endtask

    task automatic settle();
        #1 observe();
    endtask

    task automatic drive_a(input logic we, input logic [3:0] sw, input logic [15:0] wd,
                           input logic re, input logic [3:0] sr,
                           input logic [3:0] r0, input logic [3:0] r1);
        a_we = we; a_selw = sw; a_wdata = wd; a_re = re; a_selres = sr;
        a_selr = {r1, r0};
    endtask

    task automatic drive_b(input logic we, input logic [3:0] sw, input logic [15:0] wd,
                           input logic re, input logic [3:0] sr,
                           input logic [3:0] r0, input logic [3:0] r1,
                           input logic [3:0] r2, input logic [3:0] r3);
        b_we = we; b_selw = sw; b_wdata = wd; b_re = re; b_selres = sr;
        b_selr = {r3, r2, r1, r0};
    endtask

    // Called at a negedge with reset already low; returns edges until ready.
    task automatic sweep_edges_a(input int start, output int n);
        n = start;
        while (!a_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic sweep_edges_b(output int n);
        n = 0;
        while (!b_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic reset_a();
        @(negedge clk);
        a_reset = 1'b1;
        repeat (2) @(negedge clk);
        a_reset = 1'b0;
    endtask

    logic [15:0] m_reg  [16];
    logic        m_busy [16];
    logic [3:0]  rs [2];
    logic        r_we, r_re;
    logic [3:0]  r_sw, r_sr;
    logic [15:0] r_wd;
    int          n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
        drive_b(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);

        // Reset state of both banks.
        @(negedge clk);
        push("rst_a_ready", A_READY, 0, 0);
        push("rst_a_data0", A_DATA, 0, 0);
        push("rst_a_busy0", A_BUSY, 0, 0);
        push("rst_b_ready", B_READY, 0, 0);
        push("rst_b_data3", B_DATA, 3, 0);
        settle();
        @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0;
        sweep_edges_a(0, n);
        check("a_sweep_len_first", 64'(n), 64'd15);
        push("b_ready_after_first", B_READY, 0, 1);
        settle();

        // Pre-fill r5, then reset and confirm the sweep wipes it.
        @(negedge clk);
        drive_a(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd5, 4'd5);
        push("prefill_bypass", A_DATA, 0, 16'hBEEF);
        settle();
        @(negedge clk);
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
        push("prefill_stored", A_DATA, 1, 16'hBEEF);
        settle();
        a_reset = 1'b1;
        @(negedge clk);
        push("reset_mask_data", A_DATA, 0, 0);
        push("reset_ready_low", A_READY, 0, 0);
        settle();
        @(negedge clk);
        a_reset = 1'b0;
        sweep_edges_a(0, n);
        check("a_sweep_len_second", 64'(n), 64'd15);
        push("sweep_wiped_r5", A_DATA, 0, 0);
        settle();

        // Mid-sweep reset pulse, with writes/reserves offered during the sweep.
        @(negedge clk);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        repeat (7) @(negedge clk);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        n = 0;
        repeat (3) begin
            drive_a(1'b1, 4'd2, 16'hFFFF, 1'b1, 4'd2, 4'd2, 4'd2);
            push("gate_no_bypass", A_DATA, 0, 0);
            push("gate_ready_low", A_READY, 0, 0);
            settle();
            @(negedge clk);
            n++;
        end
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd2, 4'd5);
        sweep_edges_a(n, n);
        check("a_sweep_len_restart", 64'(n), 64'd15);
        push("gate_r2_data", A_DATA, 0, 0);
        push("gate_r2_busy", A_BUSY, 0, 0);
        push("gate_r5_data", A_DATA, 1, 0);
        settle();

        // Zero register ignores writes and reserves.
        @(negedge clk);
        drive_a(1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 4'd0, 4'd0);
        push("r0_write_cycle", A_DATA, 0, 0);
        push("r0_write_busy", A_BUSY, 1, 0);
        settle();
        @(negedge clk);
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd1);
        push("r0_after", A_DATA, 0, 0);
        push("r0_busy_after", A_BUSY, 0, 0);
        push("r1_untouched", A_DATA, 1, 0);
        settle();

        // Bypass to both ports, then storage.
        @(negedge clk);
        drive_a(1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0, 4'd3, 4'd3);
        push("bypass_p0", A_DATA, 0, 16'hA5A5);
        push("bypass_p1", A_DATA, 1, 16'hA5A5);
        settle();
        @(negedge clk);
        drive_a(1'b0, 4'd3, 16'h0, 1'b0, 4'd0, 4'd3, 4'd3);
        push("stored_p0", A_DATA, 0, 16'hA5A5);
        push("stored_p1", A_DATA, 1, 16'hA5A5);
        settle();

        // Scoreboard on r7.
        @(negedge clk);
        drive_a(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd7, 4'd3);
        push("reserve_not_bypassed", A_BUSY, 0, 0);
        settle();
        @(negedge clk);
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd7);
        push("reserve_busy_p0", A_BUSY, 0, 1);
        push("reserve_busy_p1", A_BUSY, 1, 1);
        push("reserve_data", A_DATA, 0, 0);
        settle();
        @(negedge clk);
        drive_a(1'b1, 4'd7, 16'h0042, 1'b0, 4'd0, 4'd7, 4'd3);
        push("wb_clear_busy", A_BUSY, 0, 0);
        push("wb_bypass_data", A_DATA, 0, 16'h0042);
        settle();
        @(negedge clk);
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd7, 4'd3);
        push("wb_busy_held", A_BUSY, 0, 0);
        push("wb_data_held", A_DATA, 0, 16'h0042);
        settle();
        @(negedge clk);
        drive_a(1'b1, 4'd7, 16'h0099, 1'b1, 4'd7, 4'd7, 4'd3);
        push("wr_res_same_bypass", A_DATA, 0, 16'h0099);
        settle();
        @(negedge clk);
        drive_a(1'b1, 4'd8, 16'h0088, 1'b1, 4'd9, 4'd7, 4'd7);
        push("wr_res_busy_wins", A_BUSY, 0, 1);
        push("wr_res_data", A_DATA, 1, 16'h0099);
        settle();
        @(negedge clk);
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd8, 4'd9);
        push("diff_idx_data", A_DATA, 0, 16'h0088);
        push("diff_idx_wbusy", A_BUSY, 0, 0);
        push("diff_idx_rbusy", A_BUSY, 1, 1);
        settle();

        // Random phase against a reference model, starting from a fresh sweep.
        reset_a();
        sweep_edges_a(0, n);
        check("a_sweep_len_rand", 64'(n), 64'd15);
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r_we = 1'($urandom_range(1));
            r_re = 1'($urandom_range(1));
            r_sw = 4'($urandom_range(15));
            r_sr = 4'($urandom_range(15));
            r_wd = 16'($urandom);
            for (int p = 0; p < 2; p++) begin
                rs[p] = ($urandom_range(3) == 0) ? r_sw : 4'($urandom_range(15));
            end
            drive_a(r_we, r_sw, r_wd, r_re, r_sr, rs[0], rs[1]);
            for (int p = 0; p < 2; p++) begin
                if (rs[p] == 4'd0) begin
                    push("rand_data", A_DATA, p, 0);
                    push("rand_busy", A_BUSY, p, 0);
                end else if (r_we && r_sw == rs[p]) begin
                    push("rand_data", A_DATA, p, 64'(r_wd));
                    push("rand_busy", A_BUSY, p, 0);
                end else begin
                    push("rand_data", A_DATA, p, 64'(m_reg[rs[p]]));
                    push("rand_busy", A_BUSY, p, 64'(m_busy[rs[p]]));
                end
            end
            settle();
            if (r_we && r_sw != 4'd0) begin
                m_reg[r_sw]  = r_wd;
                m_busy[r_sw] = 1'b0;
            end
            if (r_re && r_sr != 4'd0) begin
                m_busy[r_sr] = 1'b1;
            end
        end
        @(negedge clk);
        drive_a(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0, 4'd0);

        // Twelve-register, four-port bank.
        b_reset = 1'b1;
        repeat (2) @(negedge clk);
        b_reset = 1'b0;
        sweep_edges_b(n);
        check("b_sweep_len", 64'(n), 64'd11);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive_b(1'b1, 4'(i), 16'(i), 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        end
        @(negedge clk);
        drive_b(1'b1, 4'd11, 16'h0B0B, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        drive_b(1'b1, 4'd13, 16'h1234, 1'b1, 4'd13, 4'd13, 4'd12, 4'd0, 4'd1);
        push("b_r13_bypass_masked", B_DATA, 0, 0);
        settle();
        @(negedge clk);
        drive_b(1'b1, 4'd12, 16'h5555, 1'b1, 4'd12, 4'd13, 4'd12, 4'd0, 4'd1);
        push("b_r12_bypass_masked", B_DATA, 1, 0);
        settle();
        @(negedge clk);
        drive_b(1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 4'd13, 4'd12, 4'd0, 4'd1);
        push("b_r0_bypass_masked", B_DATA, 2, 0);
        settle();
        @(negedge clk);
        drive_b(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd13, 4'd12, 4'd0, 4'd1);
        push("b_r13_data", B_DATA, 0, 0);
        push("b_r13_busy", B_BUSY, 0, 0);
        push("b_r12_data", B_DATA, 1, 0);
        push("b_r12_busy", B_BUSY, 1, 0);
        push("b_r0_data", B_DATA, 2, 0);
        push("b_r1_unchanged", B_DATA, 3, 16'h0001);
        push("b_r1_busy", B_BUSY, 3, 0);
        settle();
        @(negedge clk);
        drive_b(1'b1, 4'd4, 16'h0040, 1'b1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4);
        push("b4_p0", B_DATA, 0, 16'h0001);
        push("b4_p1", B_DATA, 1, 16'h0002);
        push("b4_p2", B_DATA, 2, 16'h0003);
        push("b4_p3_bypass", B_DATA, 3, 16'h0040);
        settle();
        @(negedge clk);
        drive_b(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd11, 4'd2, 4'd2, 4'd2);
        push("b_last_reg", B_DATA, 0, 16'h0B0B);
        push("b_last_busy", B_BUSY, 0, 0);
        for (int p = 1; p < 4; p++) begin
            push("b_same_idx_data", B_DATA, p, 16'h0002);
            push("b_same_idx_busy", B_BUSY, p, 1);
        end
        settle();
        @(negedge clk);
        drive_b(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd4, 4'd4, 4'd15, 4'd12);
        push("b_r4_stored", B_DATA, 0, 16'h0040);
        push("b_r15_data", B_DATA, 2, 0);
        push("b_r12_again", B_DATA, 3, 0);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
